// File: rtl/fetch_line_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_line_unit                                              |
// | Description : Instruction-fetch front end. Translates the line base of    |
// |               the fetch PC, reads one cache line, then streams its        |
// |               instructions into Decode one per handshake. Supports        |
// |               unaligned entry, back-pressure, branch redirect with        |
// |               stale-response drain and a sticky halt on a zero word.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset            clock, synchronous active-high reset               |
// |   entry                 program entry PC, sampled while reset is high      |
// |   xlat_enable/_vaddr    translation request (pulse + line-aligned VA)      |
// |   xlat_ready/_paddr     translation response (pulse + PA)                  |
// |   line_enable/_paddr    line read request (pulse + registered PA)          |
// |   line_ready/_data      line read response (pulse + full line)             |
// |   redirect_valid/_pc    branch/jump redirect                               |
// |   out_valid/_ready      Decode handshake                                   |
// |   out_instr/_pc/_pcplus4 instruction, its PC and PC + instruction bytes   |
// |   out_halt              sticky, zero instruction reached                   |
// +----------------------------------------------------------------------------+
module fetch_line_unit #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int LINE_BYTES        = 64,
  parameter int LINE_WIDTH        = LINE_BYTES * 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_WIDTH-1:0]     entry,
  output logic                         xlat_enable,
  output logic [ADDRESS_WIDTH-1:0]     xlat_vaddr,
  input  logic                         xlat_ready,
  input  logic [ADDRESS_WIDTH-1:0]     xlat_paddr,
  output logic                         line_enable,
  output logic [ADDRESS_WIDTH-1:0]     line_paddr,
  input  logic                         line_ready,
  input  logic [LINE_WIDTH-1:0]        line_data,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus4,
  output logic                         out_halt
);

  localparam int INSTR_BYTES = INSTRUCTION_WIDTH / 8;
  localparam int SLOTS       = LINE_WIDTH / INSTRUCTION_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int INSTR_BITS  = $clog2(INSTR_BYTES);
  localparam int SLOT_BITS   = OFFSET_BITS - INSTR_BITS;

  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK = ADDRESS_WIDTH'(LINE_BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP     = ADDRESS_WIDTH'(INSTR_BYTES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_XLAT_REQ  = 3'd1;
  localparam logic [2:0] S_XLAT_WAIT = 3'd2;
  localparam logic [2:0] S_LINE_REQ  = 3'd3;
  localparam logic [2:0] S_LINE_WAIT = 3'd4;
  localparam logic [2:0] S_ISSUE     = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_DRAIN     = 3'd7;

  logic [2:0]                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0]     line_paddr_q, line_paddr_d;
  // Which response the DRAIN state is waiting to swallow: 1 = line, 0 = xlat.
  logic                         drain_line_q, drain_line_d;
  logic [INSTRUCTION_WIDTH-1:0] line_buf_q [SLOTS];
  logic [INSTRUCTION_WIDTH-1:0] line_buf_d [SLOTS];

  logic [INSTRUCTION_WIDTH-1:0] w_instr;
  logic                         w_last_slot;
  logic                         w_issue;
  logic                         w_zero;

  generate
    if (SLOT_BITS > 0) begin : g_multi_slot
      logic [SLOT_BITS-1:0] w_slot;
      assign w_slot      = pc_q[OFFSET_BITS-1:INSTR_BITS];
      assign w_instr     = line_buf_q[w_slot];
      // SLOTS is a power of two, so the last slot index is all ones.
      assign w_last_slot = &w_slot;
    end else begin : g_single_slot
      assign w_instr     = line_buf_q[0];
      assign w_last_slot = 1'b1;
    end
  endgenerate

  assign w_issue = (state_q == S_ISSUE);
  assign w_zero  = (w_instr == '0);

  assign xlat_enable = (state_q == S_XLAT_REQ);
  assign xlat_vaddr  = xlat_enable ? (pc_q & ~OFFSET_MASK) : '0;
  assign line_enable = (state_q == S_LINE_REQ);
  assign line_paddr  = line_paddr_q;
  assign out_valid   = w_issue & ~w_zero;
  assign out_instr   = w_issue ? w_instr : '0;
  assign out_pc      = w_issue ? pc_q : '0;
  assign out_pcplus4 = w_issue ? (pc_q + PC_STEP) : '0;
  assign out_halt    = (state_q == S_HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    line_paddr_d = line_paddr_q;
    drain_line_d = drain_line_q;
    line_buf_d   = line_buf_q;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redirect_pc;
        state_d = S_XLAT_REQ;
      end

      S_XLAT_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_XLAT_REQ;
        end else begin
          state_d = S_XLAT_WAIT;
        end
      end

      S_XLAT_WAIT: begin
        if (redirect_valid) begin
          // A response landing with the redirect is the one being drained.
          pc_d         = redirect_pc;
          drain_line_d = 1'b0;
          state_d      = xlat_ready ? S_XLAT_REQ : S_DRAIN;
        end else if (xlat_ready) begin
          line_paddr_d = xlat_paddr;
          state_d      = S_LINE_REQ;
        end
      end

      S_LINE_REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_XLAT_REQ;
        end else begin
          state_d = S_LINE_WAIT;
        end
      end

      S_LINE_WAIT: begin
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          drain_line_d = 1'b1;
          state_d      = line_ready ? S_XLAT_REQ : S_DRAIN;
        end else if (line_ready) begin
          for (int k = 0; k < SLOTS; k++) begin
            line_buf_d[k] = line_data[k*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_XLAT_REQ;
        end else if (w_zero) begin
          state_d = S_HALT;
        end else if (out_ready) begin
          pc_d = pc_q + PC_STEP;
          if (w_last_slot) state_d = S_XLAT_REQ;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) pc_d = redirect_pc;
        // The outstanding response always ends the drain, even alongside a
        // further redirect, otherwise nothing would ever release the FSM.
        if (drain_line_q ? line_ready : xlat_ready) state_d = S_XLAT_REQ;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= entry;
      line_paddr_q <= '0;
      drain_line_q <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        line_buf_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      line_paddr_q <= line_paddr_d;
      drain_line_q <= drain_line_d;
      for (int k = 0; k < SLOTS; k++) begin
        line_buf_q[k] <= line_buf_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_line_unit                                           |
// | Description : Directed self-checking bench for fetch_line_unit with a     |
// |               translation/line responder and a handshake monitor.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_line_unit;

  localparam logic [63:0] PA_OFF = 64'h0000_0000_8000_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  entry = '0;
  logic         xlat_enable;
  logic [63:0]  xlat_vaddr;
  logic         xlat_ready;
  logic [63:0]  xlat_paddr;
  logic         line_enable;
  logic [63:0]  line_paddr;
  logic         line_ready;
  logic [511:0] line_data;
  logic         redirect_valid = 1'b0;
  logic [63:0]  redirect_pc = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_instr;
  logic [63:0]  out_pc;
  logic [63:0]  out_pcplus4;
  logic         out_halt;

  fetch_line_unit dut (
    .clk(clk), .reset(reset), .entry(entry),
    .xlat_enable(xlat_enable), .xlat_vaddr(xlat_vaddr),
    .xlat_ready(xlat_ready), .xlat_paddr(xlat_paddr),
    .line_enable(line_enable), .line_paddr(line_paddr),
    .line_ready(line_ready), .line_data(line_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_halt(out_halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory image keyed by virtual address: word at 0x1000 is 0x13, +1 per word.
  logic        zero_en = 1'b0;
  logic [63:0] zero_va = '0;
  function automatic logic [31:0] mem_word(input logic [63:0] va);
    logic [63:0] w;
    w = va >> 2;
    if (zero_en && va == zero_va) return 32'h0;
    return w[31:0] - 32'h400 + 32'h13;
  endfunction

  logic [63:0] hs_pc[$];
  logic [31:0] hs_instr[$];
  int          hs_cyc[$];
  logic [63:0] xlat_q[$];

  // Responder: drives at negedge, answers after a programmable latency.
  int          xlat_lat = 1;
  int          line_lat = 1;
  int          x_cnt = 0;
  int          l_cnt = 0;
  logic [63:0] x_va = '0;
  logic [63:0] l_pa = '0;
  initial begin
    xlat_ready = 1'b0;
    line_ready = 1'b0;
    xlat_paddr = '0;
    line_data  = '0;
    forever begin
      @(negedge clk);
      xlat_ready = 1'b0;
      line_ready = 1'b0;
      if (reset) begin
        x_cnt = 0;
        l_cnt = 0;
      end else begin
        if (x_cnt > 0) begin
          x_cnt--;
          if (x_cnt == 0) begin
            xlat_ready = 1'b1;
            xlat_paddr = x_va + PA_OFF;
          end
        end
        if (l_cnt > 0) begin
          l_cnt--;
          if (l_cnt == 0) begin
            line_ready = 1'b1;
            for (int k = 0; k < 16; k++)
              line_data[k*32 +: 32] = mem_word(l_pa - PA_OFF + 64'(k*4));
          end
        end
        if (xlat_enable) begin
          x_va  = xlat_vaddr;
          x_cnt = xlat_lat;
          xlat_q.push_back(xlat_vaddr);
        end
        if (line_enable) begin
          l_pa  = line_paddr;
          l_cnt = line_lat;
        end
      end
    end
  end

  // Monitor: samples after inputs for the coming edge have settled.
  bit          hold_en = 1'b0;
  int          hold_seen = 0;
  int          cyc = 0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [63:0] p_pc = '0;
  logic [31:0] p_instr = '0;
  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (hold_en && p_valid && !p_ready) begin
        hold_seen++;
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_pc", out_pc, p_pc);
        check_eq("hold_instr", out_instr, p_instr);
      end
      if (out_valid && out_ready) begin
        hs_pc.push_back(out_pc);
        hs_instr.push_back(out_instr);
        hs_cyc.push_back(cyc);
        check_eq("instr_vs_mem", out_instr, mem_word(out_pc));
        check_eq("pcplus4", out_pcplus4, out_pc + 64'd4);
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_pc    = out_pc;
      p_instr = out_instr;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] e);
    tick();
    reset = 1'b1;
    entry = e;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    tick();
    tick();
    hs_pc.delete();
    hs_instr.delete();
    hs_cyc.delete();
    xlat_q.delete();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_xlat_enable", xlat_enable, 0);
    check_eq("rst_line_enable", line_enable, 0);
    check_eq("rst_out_halt", out_halt, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_line_paddr", line_paddr, 0);
    reset = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int budget, input string tag);
    int c = 0;
    while (hs_pc.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq(tag, 64'(hs_pc.size() >= n), 1);
  endtask

  task automatic wait_xlat(input int n, input int budget, input string tag);
    int c = 0;
    while (xlat_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq(tag, 64'(xlat_q.size() >= n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int c;
    int n_before;
    bit [3:0] pat;

    // Aligned stream
    do_reset(64'h1000);
    tick();
    check_eq("xlat_en_2nd_cycle", xlat_enable, 1);
    check_eq("xlat_vaddr_first", xlat_vaddr, 64'h1000);
    wait_hs(16, 200, "al_timeout");
    if (hs_pc.size() >= 16) begin
      check_eq("al_pc_first", hs_pc[0], 64'h1000);
      check_eq("al_pc_last", hs_pc[15], 64'h103C);
      check_eq("al_instr_first", hs_instr[0], 32'h13);
      check_eq("al_instr_last", hs_instr[15], 32'h22);
      check_eq("al_back_to_back", hs_cyc[15] - hs_cyc[0], 15);
    end
    wait_xlat(2, 50, "al_xlat_timeout");
    if (xlat_q.size() >= 2) check_eq("al_next_vaddr", xlat_q[1], 64'h1040);

    // Unaligned entry
    do_reset(64'h1010);
    wait_hs(1, 100, "ua_timeout");
    check_eq("ua_line_paddr", line_paddr, 64'h1000 + PA_OFF);
    if (hs_pc.size() >= 1) begin
      check_eq("ua_pc_first", hs_pc[0], 64'h1010);
      check_eq("ua_instr_first", hs_instr[0], 32'h17);
    end
    wait_xlat(2, 100, "ua_xlat_timeout");
    check_eq("ua_issued_count", hs_pc.size(), 12);
    if (xlat_q.size() >= 2) begin
      check_eq("ua_first_vaddr", xlat_q[0], 64'h1000);
      check_eq("ua_next_vaddr", xlat_q[1], 64'h1040);
    end

    // Back-pressure 1,0,0,1
    do_reset(64'h1000);
    hold_seen = 0;
    hold_en = 1'b1;
    pat = 4'b1001;
    c = 0;
    while (hs_pc.size() < 8 && c < 300) begin
      out_ready = pat[c % 4];
      tick();
      c++;
    end
    hold_en = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_count", 64'(hs_pc.size() >= 8), 1);
    if (hs_pc.size() >= 8)
      for (int i = 0; i < 8; i++) check_eq("bp_seq", hs_pc[i], 64'h1000 + 64'(i*4));
    check_eq("bp_stalls_seen", 64'(hold_seen > 0), 1);

    // Redirect in ISSUE at the 3rd instruction
    do_reset(64'h1000);
    c = 0;
    while (!(out_valid && out_pc == 64'h1008) && c < 100) begin
      tick();
      c++;
    end
    check_eq("rd_reach_third", out_pc, 64'h1008);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2008;
    tick();
    redirect_valid = 1'b0;
    check_eq("rd_valid_drop", out_valid, 0);
    n_before = hs_pc.size();
    check_eq("rd_consumed_third", n_before, 3);
    wait_hs(n_before + 2, 200, "rd_timeout");
    if (hs_pc.size() >= 5) begin
      check_eq("rd_first_target", hs_pc[3], 64'h2008);
      check_eq("rd_second_target", hs_pc[4], 64'h200C);
    end
    check_eq("rd_xlat_count", xlat_q.size(), 2);
    if (xlat_q.size() >= 2) check_eq("rd_xlat_vaddr", xlat_q[1], 64'h2000);

    // Redirect during LINE_WAIT, stale line drained
    line_lat = 5;
    do_reset(64'h1000);
    c = 0;
    while (!line_enable && c < 50) begin
      tick();
      c++;
    end
    check_eq("dr_line_req_seen", line_enable, 1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    wait_hs(2, 300, "dr_timeout");
    if (hs_pc.size() >= 2) begin
      check_eq("dr_first_pc", hs_pc[0], 64'h3000);
      check_eq("dr_first_instr", hs_instr[0], 32'h813);
      check_eq("dr_second_pc", hs_pc[1], 64'h3004);
    end
    check_eq("dr_xlat_count", xlat_q.size(), 2);
    if (xlat_q.size() >= 2) check_eq("dr_xlat_vaddr", xlat_q[1], 64'h3000);
    line_lat = 1;

    // Halt on zero word in slot 2, redirect ignored, reset restarts
    zero_en = 1'b1;
    zero_va = 64'h1008;
    do_reset(64'h1000);
    c = 0;
    while (!out_halt && c < 100) begin
      tick();
      c++;
    end
    check_eq("ht_halt", out_halt, 1);
    check_eq("ht_issued", hs_pc.size(), 2);
    if (hs_pc.size() >= 2) check_eq("ht_last_pc", hs_pc[1], 64'h1004);
    check_eq("ht_valid_low", out_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    check_eq("ht_sticky", out_halt, 1);
    check_eq("ht_valid_still_low", out_valid, 0);
    check_eq("ht_no_new_xlat", xlat_q.size(), 1);
    zero_en = 1'b0;
    do_reset(64'h5000);
    wait_hs(1, 100, "ht_restart_timeout");
    check_eq("ht_restart_halt_clear", out_halt, 0);
    if (hs_pc.size() >= 1) check_eq("ht_restart_pc", hs_pc[0], 64'h5000);
    if (xlat_q.size() >= 1) check_eq("ht_restart_vaddr", xlat_q[0], 64'h5000);

    // PC wrap at the top of the address space
    do_reset(64'hFFFF_FFFF_FFFF_FFF8);
    wait_hs(3, 200, "wr_timeout");
    if (hs_pc.size() >= 3) begin
      check_eq("wr_pc0", hs_pc[0], 64'hFFFF_FFFF_FFFF_FFF8);
      check_eq("wr_pc1", hs_pc[1], 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("wr_pc2", hs_pc[2], 64'h0);
    end
    if (xlat_q.size() >= 2) begin
      check_eq("wr_vaddr0", xlat_q[0], 64'hFFFF_FFFF_FFFF_FFC0);
      check_eq("wr_vaddr1", xlat_q[1], 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
